pu_or1k_wb_arbiter: RTL and testbench
=====================================

Name: pu_or1k_wb_arbiter

Overview:
Parametrised N-master Wishbone B3 arbiter for the multicore processing unit. It merges the instruction and data buses of all cores (NUM_MASTERS = 2*cores) onto one shared slave port using round-robin arbitration, and holds the grant for the whole cycle (cyc), including registered-feedback bursts. It generates the snoop_enable/snoop_adr broadcast that every core's data-cache snoop input consumes. An optional watchdog terminates stalled transfers with err.

Parameters:
NUM_MASTERS, 2, number of Wishbone masters (>=2); master i occupies slice i of each flattened bus.
AW, 32, address width.
DW, 32, data width; select width is DW/8.
TIMEOUT, 255, watchdog limit in cycles (1..65535); used only with PU_OR1K_ARB_TIMEOUT_EN.

Ports:
clk_i  in  1  clock; all state on rising edge.
rst_ni  in  1  asynchronous active-low reset.
m_adr_i  in  NUM_MASTERS*AW  master addresses.
m_dat_i  in  NUM_MASTERS*DW  master write data.
m_sel_i  in  NUM_MASTERS*DW/8  master byte selects.
m_we_i / m_cyc_i / m_stb_i  in  NUM_MASTERS each  write enable, cycle, strobe per master.
m_cti_i  in  NUM_MASTERS*3  cycle type per master.
m_bte_i  in  NUM_MASTERS*2  burst type per master.
m_dat_o  out  DW  read data, broadcast to all masters.
m_ack_o / m_err_o / m_rty_o  out  NUM_MASTERS each  terminations, granted master only.
s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  AW, DW, DW/8, 1, 1, 1, 3, 2  slave side.
s_dat_i, s_ack_i, s_err_i, s_rty_i  in  DW, 1, 1, 1  slave responses.
grant_o  out  NUM_MASTERS  one-hot current owner, registered.
snoop_enable_o  out  1  one-cycle pulse after a completed write.
snoop_adr_o  out  AW  address of that write.

Behaviour:
- Reset: state IDLE; grant_o=0; s_cyc_o=s_stb_o=s_we_o=0; all m_ack_o/m_err_o/m_rty_o=0; snoop_enable_o=0; snoop_adr_o=0; rr pointer=0. Reset asserted mid-transfer drops s_cyc_o asynchronously with no termination to the master.
- States: IDLE, BUSY.
- IDLE: if any m_cyc_i is high, pick the first requester at or after rr_ptr (wrapping modulo NUM_MASTERS). Set grant_o and go to BUSY next edge. Arbitration latency is 1 cycle.
- BUSY: s_* equals the granted slice, with cyc and stb ANDed with state==BUSY. s_ack_i/s_err_i/s_rty_i route combinationally to the granted master's m_*_o only; other masters see 0.
- Grant is held while the owner's m_cyc_i is high, regardless of cti. Bursts (cti=010) and back-to-back stb are never split.
- Release: owner's m_cyc_i low in BUSY sets rr_ptr=(owner+1) mod NUM_MASTERS.
  - If another master requests, excluding the owner, the arbiter grants it directly on the same edge (BUSY to BUSY) with no idle cycle.
  - Otherwise it goes to IDLE.
- Simultaneous requests: rr order only. The lowest index has no fixed priority; rr_ptr wraps from NUM_MASTERS-1 to 0.
- Snoop: on the cycle s_ack_i & s_we_o & s_stb_o, the next edge registers snoop_adr_o=s_adr_o and snoop_enable_o=1 for exactly one cycle. Each beat of a write burst pulses separately. err/rty never pulse.
- m_dat_o = s_dat_i unconditionally.

Optional Feature:
PU_OR1K_ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on grant change or any termination, and increments each BUSY cycle with s_stb_o high and no ack/err/rty. When the counter reaches TIMEOUT, m_err_o of the owner pulses for 1 cycle. Then s_cyc_o is forced low and state goes to IDLE (rr_ptr advanced), even if the owner keeps cyc high. A counter status output, timeout_o (1 bit, one-cycle pulse on the same cycle), is added.
- Undefined: no counter and no timeout_o; a stalled slave holds the grant indefinitely.

Test Plan:
- Single master 0 reads 0x1000; slave acks 2 cycles after s_stb_o -> grant_o=01 one cycle after cyc; m_ack_o[0] pulses once; m_dat_o=s_dat_i; snoop_enable_o stays 0.
- Masters 0 and 1 request continuously, single-beat cycles -> grants alternate 01,10,01,10; direct BUSY-to-BUSY handoff with no IDLE cycle between owners.
- Master 1 runs a 4-beat cti=010 burst while master 0 requests -> grant stays 10 through all 4 acks; master 0 is granted on the edge after master 1's cyc drops.
- Master 0 writes 0x2000_0040 and is acked -> next cycle snoop_enable_o=1, snoop_adr_o=0x2000_0040, then 0. An err-terminated write produces no pulse.
- With PU_OR1K_ARB_TIMEOUT_EN and TIMEOUT=8, slave never responds -> on the 8th stalled cycle m_err_o[owner] and timeout_o pulse; s_cyc_o drops; the next requester is granted.
- rst_ni pulled low during a burst beat -> s_cyc_o=0 and grant_o=0 immediately; after release, arbitration restarts at master 0.

Source files
------------

// File: rtl/pu_or1k_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// pu_or1k_wb_arbiter_if
// Bundles the flattened multi-master Wishbone B3 bus and the shared slave
// port used by pu_or1k_wb_arbiter. Master i occupies slice i of each
// flattened vector (e.g. m_adr_i[i*AW +: AW]).
//
// Modports:
//   slave  - arbiter view: accepts master requests and slave responses,
//            drives master terminations/read data and the slave request.
//   master - environment view (cores + shared slave): the opposite directions.
//
// Signals:
//   m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i/m_cti_i/m_bte_i  requests
//   m_dat_o/m_ack_o/m_err_o/m_rty_o                                responses
//   s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o/s_cti_o/s_bte_o  slave req
//   s_dat_i/s_ack_i/s_err_i/s_rty_i                                slave resp
// ---------------------------------------------------------------------------
interface pu_or1k_wb_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  localparam int SW = DW / 8;

  logic [NUM_MASTERS*AW-1:0] m_adr_i;
  logic [NUM_MASTERS*DW-1:0] m_dat_i;
  logic [NUM_MASTERS*SW-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS*3-1:0]  m_cti_i;
  logic [NUM_MASTERS*2-1:0]  m_bte_i;
  logic [DW-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic [NUM_MASTERS-1:0]    m_rty_o;

  logic [AW-1:0]             s_adr_o;
  logic [DW-1:0]             s_dat_o;
  logic [SW-1:0]             s_sel_o;
  logic                      s_we_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic [2:0]                s_cti_o;
  logic [1:0]                s_bte_o;
  logic [DW-1:0]             s_dat_i;
  logic                      s_ack_i;
  logic                      s_err_i;
  logic                      s_rty_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/pu_or1k_wb_arbiter.sv
// ---------------------------------------------------------------------------
// pu_or1k_wb_arbiter
// Round-robin N-master Wishbone B3 arbiter. The owner keeps the shared slave
// for its whole cyc (bursts are never split). On release the next requester
// is granted on the same edge; otherwise the arbiter idles. Completed writes
// produce a one-cycle snoop broadcast (snoop_enable_o/snoop_adr_o).
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   bus            pu_or1k_wb_arbiter_if.slave (master slices + slave port)
//   grant_o        one-hot registered current owner
//   snoop_enable_o one-cycle pulse after an acked write
//   snoop_adr_o    address of that write
//   timeout_o      watchdog pulse (only with PU_OR1K_ARB_TIMEOUT_EN)
//
// Optional feature macro: PU_OR1K_ARB_TIMEOUT_EN enables a 16-bit stall
// watchdog that terminates the owner with err after TIMEOUT stalled cycles.
// ---------------------------------------------------------------------------
module pu_or1k_wb_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  pu_or1k_wb_arbiter_if.slave    bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   snoop_enable_o,
  output logic [AW-1:0]          snoop_adr_o
`ifdef PU_OR1K_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_rr_ptr;
  logic                   r_snoop_en;
  logic [AW-1:0]          r_snoop_adr;

  logic                   w_busy;
  logic                   w_term;
  logic                   w_timeout;
  logic                   w_release;
  logic                   w_snoop_hit;
  logic [IW:0]            w_idle_pick;
  logic [IW:0]            w_hand_pick;
  logic [IW-1:0]          w_owner_next;

  // First requester at offset >= first from base (mod NUM_MASTERS).
  // Scanning from the far end lets the nearest requester win.
  function automatic logic [IW:0] f_pick(input logic [NUM_MASTERS-1:0] req,
                                         input logic [IW-1:0] base,
                                         input int first);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = NUM_MASTERS - 1; k >= first; k--) begin
      idx = IW'((int'(base) + k) % NUM_MASTERS);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_busy       = (r_state == BUSY);
  assign w_term       = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign w_idle_pick  = f_pick(bus.m_cyc_i, r_rr_ptr, 0);
  // Offsets 1..N-1 from the owner exclude the owner itself.
  assign w_hand_pick  = f_pick(bus.m_cyc_i, r_owner, 1);
  assign w_owner_next = (r_owner == IW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
  assign w_release    = w_busy & (~bus.m_cyc_i[r_owner] | w_timeout);
  assign w_snoop_hit  = bus.s_ack_i & bus.s_we_o & bus.s_stb_o;

  // Slave side mirrors the owner's slice; cyc/stb only while BUSY so an
  // asynchronous reset drops them at once.
  assign bus.s_adr_o = bus.m_adr_i[int'(r_owner)*AW +: AW];
  assign bus.s_dat_o = bus.m_dat_i[int'(r_owner)*DW +: DW];
  assign bus.s_sel_o = bus.m_sel_i[int'(r_owner)*SW +: SW];
  assign bus.s_we_o  = bus.m_we_i[r_owner];
  assign bus.s_cyc_o = w_busy & bus.m_cyc_i[r_owner];
  assign bus.s_stb_o = w_busy & bus.m_stb_i[r_owner];
  assign bus.s_cti_o = bus.m_cti_i[int'(r_owner)*3 +: 3];
  assign bus.s_bte_o = bus.m_bte_i[int'(r_owner)*2 +: 2];

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = (w_busy && bus.s_ack_i) ? r_grant : '0;
  assign bus.m_err_o = (w_busy && (bus.s_err_i || w_timeout)) ? r_grant : '0;
  assign bus.m_rty_o = (w_busy && bus.s_rty_i) ? r_grant : '0;

  assign grant_o        = r_grant;
  assign snoop_enable_o = r_snoop_en;
  assign snoop_adr_o    = r_snoop_adr;

`ifdef PU_OR1K_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  // Counter holds the number of stalled cycles already seen, so the
  // TIMEOUT-th stalled cycle fires combinationally.
  assign w_timeout = w_busy & bus.s_stb_o & ~w_term & (r_cnt == TO_LAST);
  assign timeout_o = w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (!w_busy || w_term || w_release) begin
      r_cnt <= '0;
    end else if (bus.s_stb_o) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;

  // Keeps TIMEOUT referenced when the watchdog is compiled out.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_snoop_en  <= 1'b0;
      r_snoop_adr <= '0;
    end else begin
      r_snoop_en <= w_snoop_hit;
      if (w_snoop_hit) r_snoop_adr <= bus.s_adr_o;

      case (r_state)
        IDLE: begin
          if (w_idle_pick[IW]) begin
            r_state <= BUSY;
            r_owner <= w_idle_pick[IW-1:0];
            r_grant <= NUM_MASTERS'(1) << w_idle_pick[IW-1:0];
          end
        end
        BUSY: begin
          if (w_release) begin
            r_rr_ptr <= w_owner_next;
            // A watchdog abort always idles; a normal release hands over directly.
            if (w_hand_pick[IW] && !w_timeout) begin
              r_owner <= w_hand_pick[IW-1:0];
              r_grant <= NUM_MASTERS'(1) << w_hand_pick[IW-1:0];
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pu_or1k_wb_arbiter.sv
module tb_pu_or1k_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  grant_o;
  logic        snoop_enable_o;
  logic [31:0] snoop_adr_o;
`ifdef PU_OR1K_ARB_TIMEOUT_EN
  logic        timeout_o;
`endif
  int checks = 0;
  int errors = 0;

  pu_or1k_wb_arbiter_if #(.NUM_MASTERS(2), .AW(32), .DW(32)) bus ();

  pu_or1k_wb_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .bus            (bus.slave),
    .grant_o        (grant_o),
    .snoop_enable_o (snoop_enable_o),
    .snoop_adr_o    (snoop_adr_o)
`ifdef PU_OR1K_ARB_TIMEOUT_EN
    ,
    .timeout_o      (timeout_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic cyc, input logic stb,
                            input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [2:0] cti);
    bus.m_cyc_i[m]          = cyc;
    bus.m_stb_i[m]          = stb;
    bus.m_we_i[m]           = we;
    bus.m_adr_i[m*32 +: 32] = adr;
    bus.m_dat_i[m*32 +: 32] = dat;
    bus.m_sel_i[m*4 +: 4]   = 4'hF;
    bus.m_cti_i[m*3 +: 3]   = cti;
    bus.m_bte_i[m*2 +: 2]   = 2'b00;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
    bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    step(); step(); step();
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant_o); end
    checks++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin errors++; $display("FAIL reset_s_ctrl got %b want 000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
    checks++; if ({bus.m_ack_o, bus.m_err_o, bus.m_rty_o} !== 6'b0) begin errors++; $display("FAIL reset_term got %b want 000000", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}); end
    checks++; if (snoop_enable_o !== 1'b0 || snoop_adr_o !== 32'h0) begin errors++; $display("FAIL reset_snoop got %b/%h want 0/00000000", snoop_enable_o, snoop_adr_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 3'b000);
    #1;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL read_latency got %b want 00", grant_o); end
    step(); #1;
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL read_grant got %b want 01", grant_o); end
    checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h0000_1000) begin errors++; $display("FAIL read_s_bus got %b/%h want 1/00001000", bus.s_cyc_o, bus.s_adr_o); end
    checks++; if (bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL read_wait1 got %b want 00", bus.m_ack_o); end
    step(); #1;
    checks++; if (bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL read_wait2 got %b want 00", bus.m_ack_o); end
    step();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hCAFE_F00D; #1;
    checks++; if (bus.m_ack_o !== 2'b01) begin errors++; $display("FAIL read_ack got %b want 01", bus.m_ack_o); end
    checks++; if (bus.m_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL read_data got %h want cafef00d", bus.m_dat_o); end
    step();
    bus.s_ack_i = 1'b0; set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000); #1;
    checks++; if (bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL read_ack_once got %b want 00", bus.m_ack_o); end
    checks++; if (snoop_enable_o !== 1'b0) begin errors++; $display("FAIL read_no_snoop got %b want 0", snoop_enable_o); end
    step(); #1;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL read_idle got %b want 00", grant_o); end
  endtask

  // rr_ptr is 1 here, so master 1 wins first; grants then alternate.
  task automatic test_round_robin();
    int o;
    logic [1:0] exp_g;
    logic [31:0] exp_a;
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b000);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b000);
    o = 1;
    for (int n = 0; n < 4; n++) begin
      exp_g = (o == 1) ? 2'b10 : 2'b01;
      exp_a = (o == 1) ? 32'h0000_0200 : 32'h0000_0100;
      step();
      set_master(1 - o, 1'b1, 1'b1, 1'b0, (o == 1) ? 32'h0000_0100 : 32'h0000_0200, 32'h0, 3'b000);
      bus.s_ack_i = 1'b1; #1;
      checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rr_grant%0d got %b want %b", n, grant_o, exp_g); end
      checks++; if (bus.m_ack_o !== exp_g) begin errors++; $display("FAIL rr_ack%0d got %b want %b", n, bus.m_ack_o, exp_g); end
      checks++; if (bus.s_adr_o !== exp_a) begin errors++; $display("FAIL rr_adr%0d got %h want %h", n, bus.s_adr_o, exp_a); end
      step();
      bus.s_ack_i = 1'b0; bus.m_cyc_i[o] = 1'b0; bus.m_stb_i[o] = 1'b0; #1;
      checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rr_hold%0d got %b want %b", n, grant_o, exp_g); end
      o = 1 - o;
    end
    step(); #1;
    checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rr_grant4 got %b want 10", grant_o); end
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(); #1;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_idle got %b want 00", grant_o); end
  endtask

  // rr_ptr is 0: master 1 starts alone, then master 0 requests mid-burst.
  task automatic test_burst();
    logic [4:0] pat;
    logic [1:0] exp_ack;
    int beats;
    pat = 5'b11101;
    beats = 0;
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b010);
    step(); #1;
    checks++; if (grant_o !== 2'b10 || bus.s_cti_o !== 3'b010) begin errors++; $display("FAIL burst_start got %b/%b want 10/010", grant_o, bus.s_cti_o); end
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      bus.s_ack_i = pat[i];
      set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_3000 + 32'(beats * 4), 32'h0, (i == 4) ? 3'b111 : 3'b010);
      if (pat[i]) beats++;
      exp_ack = pat[i] ? 2'b10 : 2'b00;
      #1;
      checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL burst_hold%0d got %b want 10", i, grant_o); end
      checks++; if (bus.m_ack_o !== exp_ack) begin errors++; $display("FAIL burst_ack%0d got %b want %b", i, bus.m_ack_o, exp_ack); end
    end
    step();
    bus.s_ack_i = 1'b0; set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000); #1;
    checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL burst_tail got %b want 10", grant_o); end
    step(); #1;
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL burst_handoff got %b want 01", grant_o); end
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(); #1;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL burst_idle got %b want 00", grant_o); end
  endtask

  // rr_ptr is 1, so master 0 is reached by wrapping.
  task automatic test_snoop();
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h2000_0040, 32'h1234_5678, 3'b000);
    step(); #1;
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL snoop_grant got %b want 01", grant_o); end
    bus.s_ack_i = 1'b1; #1;
    checks++; if (bus.s_we_o !== 1'b1 || bus.s_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL snoop_wdata got %b/%h want 1/12345678", bus.s_we_o, bus.s_dat_o); end
    checks++; if (snoop_enable_o !== 1'b0) begin errors++; $display("FAIL snoop_early got %b want 0", snoop_enable_o); end
    step();
    bus.s_ack_i = 1'b0; set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000); #1;
    checks++; if (snoop_enable_o !== 1'b1 || snoop_adr_o !== 32'h2000_0040) begin errors++; $display("FAIL snoop_pulse got %b/%h want 1/20000040", snoop_enable_o, snoop_adr_o); end
    step(); #1;
    checks++; if (snoop_enable_o !== 1'b0) begin errors++; $display("FAIL snoop_single got %b want 0", snoop_enable_o); end
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h2000_0080, 32'h0, 3'b000);
    step();
    bus.s_err_i = 1'b1; #1;
    checks++; if (bus.m_err_o !== 2'b01 || bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL err_route got %b/%b want 01/00", bus.m_err_o, bus.m_ack_o); end
    step();
    bus.s_err_i = 1'b0; set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000); #1;
    checks++; if (snoop_enable_o !== 1'b0) begin errors++; $display("FAIL err_no_snoop got %b want 0", snoop_enable_o); end
    step();
  endtask

  // rr_ptr is 1 before reset; after reset master 0 must win.
  task automatic test_reset_mid_burst();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 3'b010);
    step(); #1;
    checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rst_burst_grant got %b want 10", grant_o); end
    bus.s_ack_i = 1'b1;
    step();
    rst_ni = 1'b0; #1;
    checks++; if (bus.s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL rst_async got %b/%b want 0/00", bus.s_cyc_o, grant_o); end
    checks++; if (bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL rst_no_ack got %b want 00", bus.m_ack_o); end
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 3'b000);
    step(); step();
    rst_ni = 1'b1; bus.s_ack_i = 1'b0;
    step(); #1;
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rst_restart got %b want 01", grant_o); end
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(); #1;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_idle got %b want 00", grant_o); end
  endtask

`ifdef PU_OR1K_ARB_TIMEOUT_EN
  // rr_ptr is 1: master 1 owns a stalled transfer, master 0 waits.
  task automatic test_timeout();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 3'b000);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 3'b000);
    step(); #1;
    checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL to_grant got %b want 10", grant_o); end
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin step(); #1; end
      if (k < 8) begin
        checks++; if (bus.m_err_o !== 2'b00 || timeout_o !== 1'b0) begin errors++; $display("FAIL to_early%0d got %b/%b want 00/0", k, bus.m_err_o, timeout_o); end
      end else begin
        checks++; if (bus.m_err_o !== 2'b10 || timeout_o !== 1'b1) begin errors++; $display("FAIL to_fire got %b/%b want 10/1", bus.m_err_o, timeout_o); end
      end
    end
    step(); #1;
    checks++; if (bus.s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL to_drop got %b/%b want 0/00", bus.s_cyc_o, grant_o); end
    step(); #1;
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL to_next got %b want 01", grant_o); end
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(); step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_snoop();
    test_reset_mid_burst();
`ifdef PU_OR1K_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
